// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-cycle unsigned multiply / restoring divide unit
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    operation request, sampled only while not busy
//   Signal   2'b00 MULTU, 2'b01 DIVU, 2'b1x reserved (ignored)
//   dataA    multiplicand / dividend
//   dataB    multiplier / divisor
//   busy     high while iterating
//   done     one-cycle completion pulse
//   hi       product[63:32] or remainder
//   lo       product[31:0] or quotient
//   divZero  last DIVU had a zero divisor; cleared by the next accepted start
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_opnd;   // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] r_hw;     // partial product high / partial remainder
    logic [WIDTH-1:0] r_lw;     // multiplier bits / dividend shifting into quotient

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_add;
    logic [WIDTH-1:0] w_mul_hw;
    logic [WIDTH-1:0] w_mul_lw;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_qbit;
    logic [WIDTH-1:0] w_div_hw;
    logic [WIDTH-1:0] w_div_lw;
    logic [WIDTH-1:0] w_next_hw;
    logic [WIDTH-1:0] w_next_lw;

    assign w_accept = start && !Signal[1] && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        // Shift-add: the low word holds the not-yet-consumed multiplier bits;
        // each step the product (with the carry of the add) shifts right by one.
        w_add = {1'b0, r_hw} + {1'b0, r_opnd};
        if (r_lw[0]) begin
            w_mul_hw = w_add[WIDTH:1];
            w_mul_lw = {w_add[0], r_lw[WIDTH-1:1]};
        end else begin
            w_mul_hw = {1'b0, r_hw[WIDTH-1:1]};
            w_mul_lw = {r_hw[0], r_lw[WIDTH-1:1]};
        end

        // Restoring division with a 33-bit trial value. When the subtract
        // succeeds the true difference is below 2^WIDTH, so a WIDTH-bit
        // subtract of the low bits gives the exact new remainder. A zero
        // divisor naturally yields all-ones quotient and remainder = dividend.
        w_rem_sh = {r_hw, r_lw[WIDTH-1]};
        w_qbit   = (w_rem_sh >= {1'b0, r_opnd});
        w_div_hw = w_qbit ? (w_rem_sh[WIDTH-1:0] - r_opnd) : w_rem_sh[WIDTH-1:0];
        w_div_lw = {r_lw[WIDTH-2:0], w_qbit};

        if (r_state == S_DIV) begin
            w_next_hw = w_div_hw;
            w_next_lw = w_div_lw;
        end else begin
            w_next_hw = w_mul_hw;
            w_next_lw = w_mul_lw;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_opnd  <= '0;
            r_hw    <= '0;
            r_lw    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            divZero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (w_accept) begin
                        r_opnd  <= dataB;
                        r_hw    <= '0;
                        r_lw    <= dataA;
                        r_cnt   <= '0;
                        divZero <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= Signal[0] ? S_DIV : S_MUL;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_MUL, S_DIV: begin
                    r_hw  <= w_next_hw;
                    r_lw  <= w_next_lw;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        hi      <= w_next_hw;
                        lo      <= w_next_lw;
                        divZero <= (r_state == S_DIV) && (r_opnd == '0);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  Signal = 2'b00;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divZero;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .Signal  (Signal),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .divZero (divZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} from plain arithmetic.
    function automatic logic [63:0] model(input logic sig, input logic [31:0] a, input logic [31:0] b);
        if (!sig)
            return {32'h0, a} * {32'h0, b};
        else if (b == 0)
            return {a, 32'hFFFF_FFFF};
        else
            return {a % b, a / b};
    endfunction

    // Called at a negedge: present the request, step past the accepting edge.
    task automatic launch(input logic [1:0] sig, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        Signal = sig;
        dataA  = a;
        dataB  = b;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", {63'h0, busy}, 64'h1);
        chk("accept_done_low", {63'h0, done}, 64'h0);
        chk("accept_divzero_clr", {63'h0, divZero}, 64'h0);
    endtask

    // Wait for done, checking latency, busy, hi/lo stability and the result.
    // inject > 0 drives a competing MULTU request at that iteration cycle.
    task automatic complete(input logic sig, input logic [31:0] a, input logic [31:0] b, input int inject);
        logic [31:0] ph;
        logic [31:0] pl;
        logic        bad_hold;
        logic        bad_busy;
        int          n;
        ph = hi;
        pl = lo;
        bad_hold = 1'b0;
        bad_busy = 1'b0;
        n = 0;
        while (!done && n < 64) begin
            if (hi !== ph || lo !== pl) bad_hold = 1'b1;
            if (busy !== 1'b1) bad_busy = 1'b1;
            if (inject > 0 && n == inject) begin
                start  = 1'b1;
                Signal = 2'b00;
                dataA  = $urandom;
                dataB  = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n), 64'd32);
        chk("hilo_hold", {63'h0, bad_hold}, 64'h0);
        chk("busy_during", {63'h0, bad_busy}, 64'h0);
        chk("busy_at_done", {63'h0, busy}, 64'h0);
        chk("result", {hi, lo}, model(sig, a, b));
        chk("divzero", {63'h0, divZero}, {63'h0, (sig && b == 0)});
    endtask

    task automatic after_done;
        @(negedge clk);
        chk("done_one_cycle", {63'h0, done}, 64'h0);
        chk("idle_busy", {63'h0, busy}, 64'h0);
    endtask

    task automatic run(input logic sig, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        launch({1'b0, sig}, a, b);
        complete(sig, a, b, 0);
        after_done();
    endtask

    initial begin
        logic [31:0] sh;
        logic [31:0] sl;
        logic        saw_done;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_divzero", {63'h0, divZero}, 64'h0);
        rst = 1'b1;

        // Directed cases; the first start lands on the first edge after reset release
        launch(2'b00, 32'd3, 32'd15);
        complete(1'b0, 32'd3, 32'd15, 0);
        chk("mul_3x15", {hi, lo}, 64'd45);
        after_done();
        run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run(1'b1, 32'd16, 32'd4);
        run(1'b1, 32'd3, 32'd8);
        chk("div_3_8", {hi, lo}, {32'd3, 32'd0});
        run(1'b1, 32'd100, 32'd0);
        chk("div_by_zero", {hi, lo, 31'h0, divZero}, {32'd100, 32'hFFFF_FFFF, 32'h1});

        // Results and divZero hold in IDLE
        repeat (5) @(negedge clk);
        chk("idle_hold", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
        chk("idle_hold_dz", {63'h0, divZero}, 64'h1);

        // Reserved operation codes are ignored
        for (int k = 2; k < 4; k++) begin
            start  = 1'b1;
            Signal = 2'(k);
            dataA  = 32'd7;
            dataB  = 32'd9;
            @(negedge clk);
            start = 1'b0;
            chk("resv_busy", {63'h0, busy}, 64'h0);
            chk("resv_hilo", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
            chk("resv_dz", {63'h0, divZero}, 64'h1);
        end

        // Next accepted start clears divZero (checked inside launch)
        launch(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        // Competing start mid-operation is ignored
        complete(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 10);

        // Back-to-back: start held in the DONE cycle
        launch(2'b01, 32'hDEAD_BEEF, 32'd1000);
        chk("b2b_no_idle_done", {63'h0, done}, 64'h0);
        complete(1'b1, 32'hDEAD_BEEF, 32'd1000, 0);
        after_done();

        // Reset at cycle 10 of DIVU 50/7
        @(negedge clk);
        launch(2'b01, 32'd50, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", {63'h0, busy}, 64'h0);
        chk("abort_done", {63'h0, done}, 64'h0);
        chk("abort_hilo", {hi, lo}, 64'h0);
        chk("abort_dz", {63'h0, divZero}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done", {63'h0, saw_done}, 64'h0);
        chk("abort_hilo_held", {hi, lo}, 64'h0);

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if (i % 4 == 3) ra = rb * 32'($urandom_range(0, 9));
            sh = hi;
            sl = lo;
            @(negedge clk);
            launch({1'b0, rs}, ra, rb);
            chk("rand_hold_start", {hi, lo}, {sh, sl});
            complete(rs, ra, rb, 0);
            after_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
